index_decode_sequencer: RTL and testbench
=========================================

# index_decode_sequencer

Controller that runs one input tile through the input index decoder. It pulls compressed index vectors from the activation index buffer and drives the decoder's `decode_restart`, `next_a`, `stall` and `first_Ex_state_cycle` controls. It tracks divider latency so that each decoded (row, col) group reaches the multiplier array with a valid flag, a lane mask and a last flag. It sits between the tile-level control FSM and the index decoder / multiplier front end.

## Interface
Parameters:
- `I`, 4: lanes per index vector; must match the decoder.
- `NNZ_W`, 10: width of the non-zero count.
- `SIDE_W`, 6: width of the input side length.
- `DIV_LAT`, 2: divider latency in non-stalled cycles; must be at least 1.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: one-cycle pulse that launches a tile; ignored unless the block is in IDLE.
- `nnz_total`, input, NNZ_W: number of non-zero activations in the tile; sampled on `start`.
- `side_len`, input, SIDE_W: input side length; sampled on `start`.
- `idx_valid`, input, 1: the index buffer is presenting a vector to the decoder.
- `idx_ready`, output, 1: the vector is accepted this cycle.
- `ds_stall`, input, 1: downstream backpressure.
- `dec_restart`, output, 1: decoder head-index clear.
- `dec_next_a`, output, 1: decoder head-index advance.
- `dec_stall`, output, 1: decoder / divider freeze.
- `dec_first_ex`, output, 1: marks the first vector of the tile.
- `dec_side_len`, output, SIDE_W: registered copy of `side_len`.
- `out_valid`, output, 1: a decoded group is present at the decoder outputs.
- `out_mask`, output, I: valid lanes of that group.
- `out_last`, output, 1: that group is the last of the tile.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle tile-complete pulse.
- `cfg_err`, output, 1: sticky flag set by `side_len` = 0; cleared by the next accepted `start`.

## Operation
- FSM states are IDLE, INIT, RUN, DRAIN, DONE.
- IDLE -> INIT on `start`. On entry, register `nnz_total` and `side_len`, and set `vec_left` = ceil(nnz_total / I).
- Set `tail_mask`:
  - if nnz_total mod I = 0, all I lanes;
  - otherwise, the low (nnz_total mod I) lanes.
- INIT lasts one cycle with `dec_restart` = 1. Next state:
  - DONE if `vec_left` = 0;
  - DONE with `cfg_err` set if `side_len` = 0;
  - RUN otherwise.
- RUN, accept rule: `idx_ready` = `idx_valid` & !`ds_stall` & (`vec_left` != 0).
- On each accept:
  - `dec_next_a` = 1 in the same cycle;
  - `vec_left` decrements;
  - one entry is pushed into the latency pipe: mask = `tail_mask` if `vec_left` = 1, otherwise all ones; last = (`vec_left` = 1).
- `dec_first_ex` = 1 on the first accept of the tile only.
- RUN -> DRAIN on the accept that takes `vec_left` to 0.
- DRAIN: wait until the pipe is empty, which is the cycle after the `out_last` beat. Then go to DONE.
- DONE lasts one cycle: `done` = 1, then IDLE.
- `dec_stall` = `ds_stall` in all states. While stalled, the pipe holds, no accept happens, and `out_valid`/`out_mask`/`out_last` hold their values.
- `start` outside IDLE is ignored. `idx_valid` outside RUN is never accepted.
- Asserting `rst_n` low at any point, mid-tile included, clears all state immediately. Nothing from the aborted tile is emitted after reset is released.

## Timing
- Reset values:
  - all outputs 0;
  - `dec_side_len` = 0;
  - FSM in IDLE;
  - pipe empty.
- Launch: `start` in cycle 0 -> `dec_restart` in cycle 1 -> the earliest accept is in cycle 2.
- Latency: a vector accepted in cycle t yields `out_valid` in cycle t + DIV_LAT, plus one cycle for every `ds_stall` cycle in between.
- Throughput: one vector per cycle when not stalled.
- Completion: `done` rises 2 cycles after the `out_last` beat (1 cycle of DRAIN, then DONE). `busy` falls in the same cycle `done` is deasserted.
- Zero-length tile: with `nnz_total` = 0, `done` is high in cycle 2 and `out_valid` is never asserted.
- `ds_stall` rising in the same cycle as `idx_valid` takes priority: no accept happens.

## Structure
- The shared package `scnn_ctrl_pkg` holds:
  - the `idx_seq_state_e` enum;
  - the `lane_mask_t` typedef (I bits);
  - the `pipe_entry_t` struct {valid, mask, last}.
- One sub-module, `idx_seq_pipe`: a DIV_LAT-deep shift register of `pipe_entry_t` with a hold enable and an async active-low clear. It reports `empty`.
- Mask and ceiling arithmetic is done once at `start`. The divide by I is a shift; I must be a power of 2.

## Test plan
- nnz=8, I=4, side=5, no stall: 2 accepts in cycles 2–3, `dec_first_ex` in cycle 2. `out_valid` in cycles 4–5 with masks 4'b1111 and 4'b1111, `out_last` in cycle 5, `done` in cycle 7.
- nnz=6: 2 vectors, second mask 4'b0011 with `out_last`. nnz=1: a single beat, mask 4'b0001, last=1.
- nnz=0: `dec_restart` in cycle 1, `done` in cycle 2, no `idx_ready`, no `out_valid`. A separate `side_len` = 0 tile: `cfg_err` = 1, then `done`.
- `ds_stall` high for 3 cycles during RUN with `idx_valid` high: `idx_ready` = 0, outputs held, `dec_stall` = 1. The beat sequence resumes unchanged with each beat 3 cycles later.
- `start` pulsed during RUN: ignored, count unchanged. `rst_n` low mid-RUN: all outputs 0 asynchronously, block in IDLE. A new tile afterward runs cleanly.
- `idx_valid` toggling randomly over a 20-vector tile: exactly 20 accepts and 20 `out_valid` beats in order, with `out_last` only on the final beat.

Source files
------------

// File: rtl/scnn_ctrl_pkg.sv
// Shared types for the SCNN tile controllers: sequencer states, lane masks
// and the entries carried through the divider-latency pipe.
package scnn_ctrl_pkg;

  // Lanes per index vector; the sequencer's I parameter must match this.
  localparam int LANES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } idx_seq_state_e;

  typedef logic [LANES-1:0] lane_mask_t;

  typedef struct packed {
    logic       valid;
    lane_mask_t mask;
    logic       last;
  } pipe_entry_t;

  // Mask with the low `count` lanes set; a count of 0 means a full vector.
  function automatic lane_mask_t low_lanes(input int count);
    lane_mask_t m;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (count == 0) || (i < count);
    end
    return m;
  endfunction

endpackage

// File: rtl/idx_seq_pipe.sv
// Divider-latency shadow pipe: carries valid/mask/last alongside the
// decoder's divider so each decoded group emerges with its side-band flags.
module idx_seq_pipe
  import scnn_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  pipe_entry_t push_entry,
  output pipe_entry_t head_entry,
  output logic        empty
);

  pipe_entry_t [DIV_LAT-1:0] stage_reg;
  logic        [DIV_LAT-1:0] stage_valid;

  // Shift one stage per non-stalled cycle; freeze completely while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= '0;
    end else if (!hold) begin
      stage_reg[0] <= push_entry;
      for (int i = 1; i < DIV_LAT; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DIV_LAT; gi++) begin : g_valid
      assign stage_valid[gi] = stage_reg[gi].valid;
    end
  endgenerate

  assign head_entry = stage_reg[DIV_LAT-1];
  assign empty      = ~|stage_valid;

endmodule

// File: rtl/index_decode_sequencer.sv
// Runs one input tile through the index decoder: pulls index vectors,
// drives decoder controls and tags each decoded group with valid/mask/last.
module index_decode_sequencer
  import scnn_ctrl_pkg::*;
#(
  parameter int I       = 4,
  parameter int NNZ_W   = 10,
  parameter int SIDE_W  = 6,
  parameter int DIV_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NNZ_W-1:0]  nnz_total,
  input  logic [SIDE_W-1:0] side_len,
  input  logic              idx_valid,
  output logic              idx_ready,
  input  logic              ds_stall,
  output logic              dec_restart,
  output logic              dec_next_a,
  output logic              dec_stall,
  output logic              dec_first_ex,
  output logic [SIDE_W-1:0] dec_side_len,
  output logic              out_valid,
  output logic [I-1:0]      out_mask,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  // I is a power of two, so the divide by I is a right shift.
  localparam int SHIFT = $clog2(I);
  localparam logic [NNZ_W-1:0] ONE_VEC = NNZ_W'(1);

  idx_seq_state_e   state;
  logic [NNZ_W-1:0] vec_left;
  lane_mask_t       tail_mask;
  logic             first_pending;
  logic             accept;
  logic             final_vec;
  pipe_entry_t      push_entry;
  pipe_entry_t      head_entry;
  logic             pipe_empty;

  // Tile geometry computed once from the start-time inputs.
  logic [NNZ_W:0]   nnz_round;
  logic [NNZ_W-1:0] vec_count;
  lane_mask_t       start_tail;

  assign nnz_round  = {1'b0, nnz_total} + (NNZ_W+1)'(I - 1);
  assign vec_count  = NNZ_W'(nnz_round >> SHIFT);
  assign start_tail = low_lanes(int'(nnz_total & NNZ_W'(I - 1)));

  // Stall wins over a presented vector; nothing is accepted outside RUN.
  assign accept       = (state == ST_RUN) && idx_valid && !ds_stall && (vec_left != '0);
  assign final_vec    = (vec_left == ONE_VEC);
  assign idx_ready    = accept;
  assign dec_next_a   = accept;
  assign dec_first_ex = accept && first_pending;
  assign dec_stall    = ds_stall;

  assign push_entry.valid = accept;
  assign push_entry.mask  = accept ? (final_vec ? tail_mask : '1) : '0;
  assign push_entry.last  = accept && final_vec;

  idx_seq_pipe #(
    .DIV_LAT (DIV_LAT)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (ds_stall),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .empty      (pipe_empty)
  );

  assign out_valid = head_entry.valid;
  assign out_mask  = head_entry.mask;
  assign out_last  = head_entry.last;

  // Tile control FSM with registered restart/busy/done/cfg_err outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      vec_left      <= '0;
      tail_mask     <= '0;
      first_pending <= 1'b0;
      dec_side_len  <= '0;
      dec_restart   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      dec_restart <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_INIT;
            vec_left      <= vec_count;
            tail_mask     <= start_tail;
            dec_side_len  <= side_len;
            first_pending <= 1'b1;
            cfg_err       <= 1'b0;
            dec_restart   <= 1'b1;
            busy          <= 1'b1;
          end
        end
        ST_INIT: begin
          if (vec_left == '0 || dec_side_len == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
            if (dec_side_len == '0) cfg_err <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            vec_left      <= vec_left - ONE_VEC;
            first_pending <= 1'b0;
            if (final_vec) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_index_decode_sequencer.sv
// Directed bench for index_decode_sequencer: per-tile cycle bitmaps checked
// against hand-computed expectations.
module tb_index_decode_sequencer;

  localparam int I       = 4;
  localparam int NNZ_W   = 10;
  localparam int SIDE_W  = 6;
  localparam int DIV_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [NNZ_W-1:0]  nnz_total = '0;
  logic [SIDE_W-1:0] side_len = '0;
  logic              idx_valid = 1'b0;
  logic              ds_stall = 1'b0;
  logic              idx_ready, dec_restart, dec_next_a, dec_stall, dec_first_ex;
  logic [SIDE_W-1:0] dec_side_len;
  logic              out_valid, out_last, busy, done, cfg_err;
  logic [I-1:0]      out_mask;

  index_decode_sequencer #(
    .I(I), .NNZ_W(NNZ_W), .SIDE_W(SIDE_W), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nnz_total(nnz_total),
    .side_len(side_len), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .ds_stall(ds_stall), .dec_restart(dec_restart), .dec_next_a(dec_next_a),
    .dec_stall(dec_stall), .dec_first_ex(dec_first_ex),
    .dec_side_len(dec_side_len), .out_valid(out_valid), .out_mask(out_mask),
    .out_last(out_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Per-tile records: bit c of each bitmap is the signal in tile cycle c.
  logic [63:0]       b_ready, b_valid, b_last, b_done, b_restart, b_first;
  logic [63:0]       b_busy, b_dstall, b_cfg, mask_seq;
  int                n_ready, n_beats, n_last, n_done, n_badmask, last_beat_idx;
  logic [I-1:0]      last_mask;
  logic [SIDE_W-1:0] side_seen;

  // Cycle 0 pulses start; inputs change 1ns after posedge, outputs sampled at negedge.
  task automatic run_tile(input int nnz, input int side, input int ncyc,
                          input logic [63:0] valid_m, input logic [63:0] stall_m,
                          input logic [63:0] start_m, input bit rnd);
    b_ready = '0; b_valid = '0; b_last = '0; b_done = '0; b_restart = '0;
    b_first = '0; b_busy = '0; b_dstall = '0; b_cfg = '0; mask_seq = '0;
    n_ready = 0; n_beats = 0; n_last = 0; n_done = 0; n_badmask = 0;
    last_beat_idx = 0; last_mask = '0; side_seen = '0;
    for (int c = 0; c < ncyc; c++) begin
      start     = (c == 0) || ((c < 64) ? start_m[c[5:0]] : 1'b0);
      nnz_total = (c == 0) ? NNZ_W'(nnz) : NNZ_W'(3);
      side_len  = (c == 0) ? SIDE_W'(side) : SIDE_W'(7);
      idx_valid = rnd ? 1'($urandom_range(0, 1)) : ((c < 64) ? valid_m[c[5:0]] : 1'b0);
      ds_stall  = (c < 64) ? stall_m[c[5:0]] : 1'b0;
      @(negedge clk);
      if (c < 64) begin
        b_ready[c]   = idx_ready;
        b_valid[c]   = out_valid;
        b_last[c]    = out_last;
        b_done[c]    = done;
        b_restart[c] = dec_restart;
        b_first[c]   = dec_first_ex;
        b_busy[c]    = busy;
        b_dstall[c]  = dec_stall;
        b_cfg[c]     = cfg_err;
      end
      if (c == 1) side_seen = dec_side_len;
      if (idx_ready) n_ready++;
      if (done) n_done++;
      if (out_valid && !ds_stall) begin
        n_beats++;
        mask_seq = {mask_seq[59:0], out_mask};
        if (out_last) begin
          n_last++;
          last_beat_idx = n_beats;
          last_mask = out_mask;
        end else if (out_mask != 4'hF) begin
          n_badmask++;
        end
        $display("beat %0d cycle %0d mask=%b last=%b", n_beats, c, out_mask, out_last);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    idx_valid = 1'b0;
    ds_stall = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idle_valid;
    int idle_ready;

    // Reset state, with idx_valid asserted to show nothing is accepted.
    idx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", {busy, done, out_valid, out_mask, out_last, idx_ready,
                            dec_restart, dec_next_a, dec_first_ex, dec_stall,
                            cfg_err, dec_side_len}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_ready", {busy, idx_ready, out_valid}, 64'h0);
    idx_valid = 1'b0;

    // nnz=8: two full vectors, no stall.
    run_tile(8, 5, 10, '1, '0, '0, 1'b0);
    check_eq("n8_restart", b_restart, 64'h2);
    check_eq("n8_ready", b_ready, 64'hC);
    check_eq("n8_first", b_first, 64'h4);
    check_eq("n8_valid", b_valid, 64'h30);
    check_eq("n8_last", b_last, 64'h20);
    check_eq("n8_masks", mask_seq, 64'hFF);
    check_eq("n8_done", b_done, 64'h80);
    check_eq("n8_busy", b_busy, 64'hFE);
    check_eq("n8_side", side_seen, 64'd5);
    check_eq("n8_dstall", b_dstall, 64'h0);

    // nnz=6: partial tail vector.
    run_tile(6, 5, 10, '1, '0, '0, 1'b0);
    check_eq("n6_ready", b_ready, 64'hC);
    check_eq("n6_valid", b_valid, 64'h30);
    check_eq("n6_masks", mask_seq, 64'hF3);
    check_eq("n6_last", b_last, 64'h20);
    check_eq("n6_done", b_done, 64'h80);

    // nnz=1: single beat.
    run_tile(1, 5, 8, '1, '0, '0, 1'b0);
    check_eq("n1_ready", b_ready, 64'h4);
    check_eq("n1_masks", mask_seq, 64'h1);
    check_eq("n1_last", b_last, 64'h10);
    check_eq("n1_done", b_done, 64'h40);

    // nnz=0: restart then immediate done.
    run_tile(0, 5, 6, '1, '0, '0, 1'b0);
    check_eq("n0_restart", b_restart, 64'h2);
    check_eq("n0_done", b_done, 64'h4);
    check_eq("n0_ready", b_ready, 64'h0);
    check_eq("n0_valid", b_valid, 64'h0);
    check_eq("n0_busy", b_busy, 64'h6);

    // side_len=0: configuration error, sticky until next start.
    run_tile(4, 0, 6, '1, '0, '0, 1'b0);
    check_eq("cfg_flag", b_cfg, 64'h3C);
    check_eq("cfg_done", b_done, 64'h4);
    check_eq("cfg_ready", b_ready, 64'h0);
    check_eq("cfg_valid", b_valid, 64'h0);

    // nnz=11 with ds_stall in cycles 4..6.
    run_tile(11, 3, 14, '1, 64'h70, '0, 1'b0);
    check_eq("st_cfg_clear", b_cfg, 64'h1);
    check_eq("st_ready", b_ready, 64'h8C);
    check_eq("st_valid", b_valid, 64'h3F0);
    check_eq("st_last", b_last, 64'h200);
    check_eq("st_masks", mask_seq, 64'hFF7);
    check_eq("st_dstall", b_dstall, 64'h70);
    check_eq("st_done", b_done, 64'h800);

    // start pulses during RUN and DRAIN are ignored.
    run_tile(8, 5, 10, '1, '0, 64'h24, 1'b0);
    check_eq("rs_restart", b_restart, 64'h2);
    check_eq("rs_ready", b_ready, 64'hC);
    check_eq("rs_masks", mask_seq, 64'hFF);
    check_eq("rs_done", b_done, 64'h80);

    // Asynchronous reset in the middle of a 20-vector tile.
    run_tile(80, 5, 5, '1, '0, '0, 1'b0);
    idx_valid = 1'b1;
    #1;
    check_eq("mid_ready", {busy, idx_ready}, 64'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_clear", {busy, done, out_valid, out_mask, out_last, idx_ready,
                             dec_restart, dec_next_a, dec_first_ex, cfg_err,
                             dec_side_len}, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_valid = 0;
    idle_ready = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) idle_valid++;
      if (idx_ready || busy) idle_ready++;
      @(posedge clk);
      #1;
    end
    check_eq("post_rst_valid", idle_valid, 64'd0);
    check_eq("post_rst_idle", idle_ready, 64'd0);
    idx_valid = 1'b0;

    run_tile(6, 5, 10, '1, '0, '0, 1'b0);
    check_eq("re_ready", b_ready, 64'hC);
    check_eq("re_masks", mask_seq, 64'hF3);
    check_eq("re_done", b_done, 64'h80);

    // Random idx_valid over a 20-vector tile (78 = 19*4 + 2).
    run_tile(78, 5, 120, '0, '0, '0, 1'b1);
    check_eq("rnd_accepts", n_ready, 64'd20);
    check_eq("rnd_beats", n_beats, 64'd20);
    check_eq("rnd_lasts", n_last, 64'd1);
    check_eq("rnd_last_idx", last_beat_idx, 64'd20);
    check_eq("rnd_last_mask", last_mask, 64'h3);
    check_eq("rnd_badmask", n_badmask, 64'd0);
    check_eq("rnd_done", n_done, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
